// File: rtl/system_bus_arbiter.sv
// Two-master system bus arbiter: fixed or round-robin tie-break, lock chaining
// up to a fairness limit, and a watchdog that revokes stalled grants.
module system_bus_arbiter #(
  parameter int unsigned PRIORITY_MODE  = 0,
  parameter int unsigned MAX_LOCK_TXNS  = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd200
) (
  input  logic clk,
  input  logic reset,
  input  logic m1_req,
  input  logic m1_lock,
  input  logic m2_req,
  input  logic m2_lock,
  input  logic txn_done,
  output logic m1_grant,
  output logic m2_grant,
  output logic bus_busy,
  output logic owner,
  output logic timeout_abort
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [15:0] WD_LAST   = TIMEOUT_CYCLES - 16'd1;
  localparam logic [3:0]  LOCK_LAST = 4'(MAX_LOCK_TXNS - 32'd1);
  localparam logic        OWNER_M1  = 1'b0;
  localparam logic        OWNER_M2  = 1'b1;

  state_t      state_r, state_s;
  logic        owner_r, owner_s;
  logic        last_owner_r, last_owner_s;
  logic [3:0]  lock_cnt_r, lock_cnt_s;
  logic [15:0] wd_r, wd_s;
  logic        abort_s;
  logic        winner_s;
  logic        owner_req_s, owner_lock_s;
  logic [15:0] wd_inc_s;
  logic        wd_expired_s;

  assign owner_req_s  = owner_r ? m2_req  : m1_req;
  assign owner_lock_s = owner_r ? m2_lock : m1_lock;
  assign wd_inc_s     = (wd_r == 16'hFFFF) ? wd_r : wd_r + 16'd1;
  assign wd_expired_s = (wd_r == WD_LAST);
  assign owner        = owner_r;

  // Winner selection when the bus is free.
  always_comb begin
    winner_s = OWNER_M1;
    if (m1_req && m2_req) begin
      if (PRIORITY_MODE == 32'd1) begin
        winner_s = ~last_owner_r;
      end else begin
        winner_s = OWNER_M1;
      end
    end else if (m2_req) begin
      winner_s = OWNER_M2;
    end else begin
      winner_s = OWNER_M1;
    end
  end

  // Next-state logic; in BUSY completion beats expiry, which beats withdraw.
  always_comb begin
    state_s      = state_r;
    owner_s      = owner_r;
    last_owner_s = last_owner_r;
    lock_cnt_s   = lock_cnt_r;
    wd_s         = wd_r;
    abort_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (m1_req || m2_req) begin
          state_s      = BUSY;
          owner_s      = winner_s;
          last_owner_s = winner_s;
          lock_cnt_s   = 4'd0;
          wd_s         = 16'd0;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        wd_s = wd_inc_s;
        if (txn_done) begin
          if (owner_lock_s && (lock_cnt_r < LOCK_LAST)) begin
            lock_cnt_s = lock_cnt_r + 4'd1;
            state_s    = LOCKED;
          end else begin
            state_s = IDLE;
          end
        end else if (wd_expired_s) begin
          state_s = IDLE;
          abort_s = 1'b1;
        end else if (!owner_req_s) begin
          state_s = IDLE;
        end else begin
          state_s = BUSY;
        end
      end
      LOCKED: begin
        wd_s = wd_inc_s;
        if (owner_req_s) begin
          wd_s    = 16'd0;
          state_s = BUSY;
        end else if (wd_expired_s) begin
          state_s = IDLE;
          abort_s = 1'b1;
        end else if (!owner_lock_s) begin
          state_s = IDLE;
        end else begin
          state_s = LOCKED;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs; grants decode from one state so they never overlap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      owner_r       <= OWNER_M1;
      last_owner_r  <= OWNER_M2;
      lock_cnt_r    <= 4'd0;
      wd_r          <= 16'd0;
      m1_grant      <= 1'b0;
      m2_grant      <= 1'b0;
      bus_busy      <= 1'b0;
      timeout_abort <= 1'b0;
    end else begin
      state_r       <= state_s;
      owner_r       <= owner_s;
      last_owner_r  <= last_owner_s;
      lock_cnt_r    <= lock_cnt_s;
      wd_r          <= wd_s;
      m1_grant      <= (state_s != IDLE) && (owner_s == OWNER_M1);
      m2_grant      <= (state_s != IDLE) && (owner_s == OWNER_M2);
      bus_busy      <= (state_s != IDLE);
      timeout_abort <= abort_s;
    end
  end

endmodule

// File: tb/tb_system_bus_arbiter.sv
// Fixed-priority and round-robin arbiter instances driven by shared stimulus and
// compared against a transaction-level reference model of the arbitration rules.
module tb_system_bus_arbiter;
  localparam int MAX_LOCK = 4;
  localparam int TIMEOUT  = 10;

  logic clk, reset;
  logic m1_req, m1_lock, m2_req, m2_lock, txn_done;
  logic m1_grant_fp, m2_grant_fp, bus_busy_fp, owner_fp, timeout_abort_fp;
  logic m1_grant_rr, m2_grant_rr, bus_busy_rr, owner_rr, timeout_abort_rr;
  int   vectors, miscompares;

  // Reference model per instance, index = priority mode (0 fixed, 1 round-robin).
  int holder[2];          // master holding the bus, -1 when free
  int last_win[2];
  int done_in_tenure[2];  // transactions completed since the grant was issued
  int age[2];             // cycles since the current transaction phase began
  bit between_txns[2];    // lock keeps the bus between chained transactions
  bit shown_owner[2];
  bit abort_now[2];

  system_bus_arbiter #(.PRIORITY_MODE(0), .MAX_LOCK_TXNS(MAX_LOCK), .TIMEOUT_CYCLES(16'd10)) dut_fp (
    .clk(clk), .reset(reset), .m1_req(m1_req), .m1_lock(m1_lock), .m2_req(m2_req),
    .m2_lock(m2_lock), .txn_done(txn_done), .m1_grant(m1_grant_fp), .m2_grant(m2_grant_fp),
    .bus_busy(bus_busy_fp), .owner(owner_fp), .timeout_abort(timeout_abort_fp));

  system_bus_arbiter #(.PRIORITY_MODE(1), .MAX_LOCK_TXNS(MAX_LOCK), .TIMEOUT_CYCLES(16'd10)) dut_rr (
    .clk(clk), .reset(reset), .m1_req(m1_req), .m1_lock(m1_lock), .m2_req(m2_req),
    .m2_lock(m2_lock), .txn_done(txn_done), .m1_grant(m1_grant_rr), .m2_grant(m2_grant_rr),
    .bus_busy(bus_busy_rr), .owner(owner_rr), .timeout_abort(timeout_abort_rr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset(input int m);
    holder[m] = -1; last_win[m] = 1; done_in_tenure[m] = 0; age[m] = 0;
    between_txns[m] = 1'b0; shown_owner[m] = 1'b0; abort_now[m] = 1'b0;
  endfunction

  function automatic void model_step(input int m);
    bit req[2];
    bit lck[2];
    int h;
    req[0] = m1_req; req[1] = m2_req; lck[0] = m1_lock; lck[1] = m2_lock;
    h = holder[m];
    abort_now[m] = 1'b0;
    if (h < 0) begin
      if (req[0] || req[1]) begin
        if (req[0] && req[1]) h = (m == 1) ? 1 - last_win[m] : 0;
        else h = req[0] ? 0 : 1;
        last_win[m] = h; shown_owner[m] = (h == 1);
        done_in_tenure[m] = 0; age[m] = 0; between_txns[m] = 1'b0;
      end
    end else if (!between_txns[m]) begin
      if (txn_done) begin
        done_in_tenure[m]++;
        if (lck[h] && done_in_tenure[m] < MAX_LOCK) begin
          between_txns[m] = 1'b1; age[m]++;
        end else h = -1;
      end else if (age[m] == TIMEOUT - 1) begin
        h = -1; abort_now[m] = 1'b1;
      end else if (!req[h]) h = -1;
      else age[m]++;
    end else begin
      if (req[h]) begin
        between_txns[m] = 1'b0; age[m] = 0;
      end else if (age[m] == TIMEOUT - 1) begin
        h = -1; abort_now[m] = 1'b1;
      end else if (!lck[h]) h = -1;
      else age[m]++;
    end
    holder[m] = h;
  endfunction

  function automatic logic [4:0] exp_vec(input int m);
    return {holder[m] == 0, holder[m] == 1, holder[m] >= 0, shown_owner[m], abort_now[m]};
  endfunction

  function automatic logic [4:0] obs_vec(input int m);
    if (m == 1) return {m1_grant_rr, m2_grant_rr, bus_busy_rr, owner_rr, timeout_abort_rr};
    else return {m1_grant_fp, m2_grant_fp, bus_busy_fp, owner_fp, timeout_abort_fp};
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (!reset) model_reset(m);
      else model_step(m);
    end
    #1;
  endtask

  task automatic apply_reset();
    {m1_req, m1_lock, m2_req, m2_lock, txn_done} = 5'b0;
    reset = 1'b0;
    for (int m = 0; m < 2; m++) model_reset(m);
    repeat (2) tick();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int m = 0; m < 2; m++) model_reset(m);
    {m1_req, m1_lock, m2_req, m2_lock, txn_done} = 5'b10101;
    repeat (3) tick();
    vectors++;
    if ({obs_vec(0), obs_vec(1)} !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_values: got %b want %b", {obs_vec(0), obs_vec(1)}, 10'd0);
    end
    {m1_req, m1_lock, m2_req, m2_lock, txn_done} = 5'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        vectors++;
        if (obs_vec(m) !== exp_vec(m)) begin
          miscompares++;
          $display("FAIL reset_idle mode%0d: got %b want %b", m, obs_vec(m), exp_vec(m));
        end
      end
    end
  endtask

  task automatic test_m1_only();
    m1_req = 1'b1;
    tick();
    vectors++;
    if ({m1_grant_fp, m1_grant_rr, m2_grant_fp, m2_grant_rr} !== 4'b1100) begin
      miscompares++;
      $display("FAIL m1_only_grant: got %b want 1100", {m1_grant_fp, m1_grant_rr, m2_grant_fp, m2_grant_rr});
    end
    for (int i = 0; i < 7; i++) begin
      txn_done = (i == 5);
      tick();
      if (i == 5) begin txn_done = 1'b0; m1_req = 1'b0; end
      for (int m = 0; m < 2; m++) begin
        vectors++;
        if (obs_vec(m) !== exp_vec(m)) begin
          miscompares++;
          $display("FAIL m1_only mode%0d cyc%0d: got %b want %b", m, i, obs_vec(m), exp_vec(m));
        end
      end
    end
    vectors++;
    if ({m1_grant_fp, m1_grant_rr, bus_busy_fp, bus_busy_rr} !== 4'b0000) begin
      miscompares++;
      $display("FAIL m1_only_release: got %b want 0000", {m1_grant_fp, m1_grant_rr, bus_busy_fp, bus_busy_rr});
    end
  endtask

  task automatic test_tie();
    apply_reset();
    m1_req = 1'b1; m2_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if ({m1_grant_rr, m2_grant_rr, m1_grant_fp} !== {k != 1, k == 1, 1'b1}) begin
        miscompares++;
        $display("FAIL tie_grant k%0d: got %b want %b", k, {m1_grant_rr, m2_grant_rr, m1_grant_fp}, {k != 1, k == 1, 1'b1});
      end
      txn_done = 1'b1;
      tick();
      txn_done = 1'b0;
      vectors++;
      if ({bus_busy_rr, bus_busy_fp} !== 2'b00) begin
        miscompares++;
        $display("FAIL tie_idle_gap k%0d: got %b want 00", k, {bus_busy_rr, bus_busy_fp});
      end
    end
    m1_req = 1'b0; m2_req = 1'b0;
    tick();
  endtask

  task automatic test_lock_chain();
    apply_reset();
    m1_req = 1'b1; m1_lock = 1'b1; m2_req = 1'b1;
    tick();
    for (int t = 1; t <= 4; t++) begin
      tick();
      txn_done = 1'b1;
      tick();
      txn_done = 1'b0;
      vectors++;
      if ({m1_grant_fp, m1_grant_rr} !== {2{t < 4}}) begin
        miscompares++;
        $display("FAIL lock_chain_hold t%0d: got %b want %b", t, {m1_grant_fp, m1_grant_rr}, {2{t < 4}});
      end
      for (int m = 0; m < 2; m++) begin
        vectors++;
        if (obs_vec(m) !== exp_vec(m)) begin
          miscompares++;
          $display("FAIL lock_chain mode%0d t%0d: got %b want %b", m, t, obs_vec(m), exp_vec(m));
        end
      end
    end
    tick();
    vectors++;
    if ({m2_grant_rr, m1_grant_fp} !== 2'b11) begin
      miscompares++;
      $display("FAIL lock_chain_handover: got %b want 11", {m2_grant_rr, m1_grant_fp});
    end
    {m1_req, m1_lock, m2_req} = 3'b000;
    tick();
  endtask

  task automatic test_watchdog();
    apply_reset();
    m2_req = 1'b1;
    tick();
    m1_req = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      vectors++;
      if ({m2_grant_fp, m2_grant_rr, timeout_abort_fp, timeout_abort_rr} !== 4'b1100) begin
        miscompares++;
        $display("FAIL watchdog_hold i%0d: got %b want 1100", i, {m2_grant_fp, m2_grant_rr, timeout_abort_fp, timeout_abort_rr});
      end
    end
    tick();
    vectors++;
    if ({m2_grant_fp, m2_grant_rr, timeout_abort_fp, timeout_abort_rr} !== 4'b0011) begin
      miscompares++;
      $display("FAIL watchdog_expire: got %b want 0011", {m2_grant_fp, m2_grant_rr, timeout_abort_fp, timeout_abort_rr});
    end
    tick();
    vectors++;
    if ({m1_grant_fp, m1_grant_rr, timeout_abort_fp, timeout_abort_rr} !== 4'b1100) begin
      miscompares++;
      $display("FAIL watchdog_next: got %b want 1100", {m1_grant_fp, m1_grant_rr, timeout_abort_fp, timeout_abort_rr});
    end
    m1_req = 1'b0; m2_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_locked();
    apply_reset();
    m1_req = 1'b1; m1_lock = 1'b1;
    tick();
    txn_done = 1'b1;
    tick();
    txn_done = 1'b0; m1_req = 1'b0;
    tick();
    vectors++;
    if ({m1_grant_fp, m1_grant_rr} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_mid_locked_held: got %b want 11", {m1_grant_fp, m1_grant_rr});
    end
    #2 reset = 1'b0;
    for (int m = 0; m < 2; m++) model_reset(m);
    #1;
    vectors++;
    if ({m1_grant_fp, m1_grant_rr, bus_busy_fp, bus_busy_rr, owner_fp, owner_rr} !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_async_drop: got %b want 000000", {m1_grant_fp, m1_grant_rr, bus_busy_fp, bus_busy_rr, owner_fp, owner_rr});
    end
    m1_lock = 1'b0; m1_req = 1'b1; m2_req = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    tick();
    vectors++;
    if ({m1_grant_rr, m2_grant_rr} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_rr_first: got %b want 10", {m1_grant_rr, m2_grant_rr});
    end
    m1_req = 1'b0; m2_req = 1'b0;
    tick();
  endtask

  task automatic test_withdraw();
    apply_reset();
    m1_req = 1'b1;
    repeat (3) tick();
    m1_req = 1'b0;
    tick();
    vectors++;
    if ({m1_grant_fp, m1_grant_rr, timeout_abort_fp, timeout_abort_rr} !== 4'b0000) begin
      miscompares++;
      $display("FAIL withdraw_drop: got %b want 0000", {m1_grant_fp, m1_grant_rr, timeout_abort_fp, timeout_abort_rr});
    end
    tick();
    vectors++;
    if ({timeout_abort_fp, timeout_abort_rr, bus_busy_fp, bus_busy_rr} !== 4'b0000) begin
      miscompares++;
      $display("FAIL withdraw_no_abort: got %b want 0000", {timeout_abort_fp, timeout_abort_rr, bus_busy_fp, bus_busy_rr});
    end
  endtask

  task automatic test_random();
    for (int blk = 0; blk < 10; blk++) begin
      int pdone;
      pdone = int'($urandom_range(2, 40));
      if (blk % 4 == 0) apply_reset();
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 99) < 15) m1_req = ~m1_req;
        if ($urandom_range(0, 99) < 15) m2_req = ~m2_req;
        if ($urandom_range(0, 99) < 20) m1_lock = ~m1_lock;
        if ($urandom_range(0, 99) < 20) m2_lock = ~m2_lock;
        txn_done = ($urandom_range(0, 99) < pdone);
        tick();
        for (int m = 0; m < 2; m++) begin
          vectors++;
          if (obs_vec(m) !== exp_vec(m)) begin
            miscompares++;
            $display("FAIL random mode%0d blk%0d cyc%0d: got %b want %b", m, blk, i, obs_vec(m), exp_vec(m));
          end
        end
      end
    end
    {m1_req, m1_lock, m2_req, m2_lock, txn_done} = 5'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    {m1_req, m1_lock, m2_req, m2_lock, txn_done} = 5'b0;
    test_reset();
    test_m1_only();
    test_tie();
    test_lock_chain();
    test_watchdog();
    test_reset_mid_locked();
    test_withdraw();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/system_bus_arbiter.md
# system_bus_arbiter

Two-master bus arbiter for the system bus. It sits between the master interfaces of master 1 and master 2 and the shared bus, and issues a single grant at a time. It honours each master's lock request (force-hold across back-to-back transactions) up to a fairness limit. A watchdog reclaims the bus from a master that never completes its transaction.

## Interface
Parameters:
- `PRIORITY_MODE`, default 0. 0 = fixed priority, M1 wins ties. 1 = round-robin, the master that did not own the bus last wins ties.
- `MAX_LOCK_TXNS`, default 4. Maximum number of consecutive transactions one owner may chain via lock before a forced release. Range 1..15.
- `TIMEOUT_CYCLES`, default 16'd200. Number of BUSY cycles without `txn_done` before the grant is revoked. Must be ≥ 1.

Ports:
- `clk`  in  1  Clock.
- `reset`  in  1  Reset: reset reset, asynchronous, active-low; clock clk.
- `m1_req`  in  1  Master 1 requests the bus. Held high until its transaction completes.
- `m1_lock`  in  1  Master 1 wants to keep the bus after the current transaction.
- `m2_req`  in  1  Master 2 requests the bus.
- `m2_lock`  in  1  Master 2 lock request.
- `txn_done`  in  1  One-cycle pulse from the bus: the current owner's transaction has completed.
- `m1_grant`  out  1  Bus granted to master 1.
- `m2_grant`  out  1  Bus granted to master 2.
- `bus_busy`  out  1  High whenever either grant is high.
- `owner`  out  1  0 = M1, 1 = M2. Last or current owner; meaningful while `bus_busy` is high.
- `timeout_abort`  out  1  One-cycle pulse when the watchdog revokes a grant.

## Operation
- States: IDLE, BUSY, LOCKED. All outputs are registered.
- Reset values: state IDLE, all grants 0, `bus_busy` 0, `owner` 0, `timeout_abort` 0, `last_owner` = M2 (so M1 wins the first tie in round-robin), lock counter 0, watchdog 0.
- IDLE:
  - If any request is sampled high, pick a winner, assert its grant, set `owner`/`last_owner`, clear the watchdog and lock counter, and go to BUSY.
  - With a single request, that master wins.
  - With both requesting, `PRIORITY_MODE`=0 picks M1; `PRIORITY_MODE`=1 picks the master that is not `last_owner`.
- BUSY:
  - The watchdog increments each cycle.
  - On `txn_done`:
    - If the owner's lock is high and the lock counter < `MAX_LOCK_TXNS`-1: increment the lock counter, keep the grant, go to LOCKED.
    - Otherwise: drop the grant and go to IDLE.
  - If the owner's `req` is sampled low without `txn_done` (master withdrew): drop the grant and go to IDLE.
  - If the watchdog reaches `TIMEOUT_CYCLES`-1 with no `txn_done`: drop the grant, pulse `timeout_abort`, go to IDLE.
- LOCKED:
  - The grant is held and the watchdog runs.
  - Owner `req` high: clear the watchdog, go to BUSY.
  - Owner `lock` and `req` both low: drop the grant, go to IDLE.
  - Watchdog expiry: same action as in BUSY.
  - The non-owner's `req` is ignored.
- Simultaneous events in BUSY, in priority order: `txn_done` over timeout over req-withdraw. `txn_done` in the expiry cycle counts as completion; no abort.
- Lock on the `MAX_LOCK_TXNS`-th chained transaction is ignored: the grant drops and the bus goes to IDLE. In round-robin mode a waiting other master then wins.
- Requests and `txn_done` arriving while in IDLE with no grant are meaningless; `txn_done` is ignored in IDLE.
- Widths: watchdog 16 bits, saturating, compared with `==`. Lock counter 4 bits.
- The two grants are never high together. This is enforced by the state encoding.

## Timing
- Grant latency: a request sampled at edge k in IDLE gives a grant visible from cycle k+1.
- Release: the grant falls on the edge that samples `txn_done`, withdraw, or expiry.
- After every release, at least one IDLE cycle passes before the next grant is issued, including a re-grant to the same master.
- Lock continuation: the grant stays high continuously through BUSY→LOCKED→BUSY.
- `timeout_abort` is high for exactly the cycle after the expiry edge, coincident with the grant being low.
- Reset mid-operation: grants drop immediately (asynchronously) and all state returns to reset values. After reset deasserts, arbitration restarts from IDLE.

## Test plan
- M1 only: `m1_req`=1 at cycle 5 → `m1_grant`=1 from cycle 6; `txn_done` pulse at 12 → `m1_grant`=0 at 13, `bus_busy`=0.
- Tie, `PRIORITY_MODE`=1: both requests held high → grants go M1, then M2, then M1, each separated by one IDLE cycle. With `PRIORITY_MODE`=0 under the same stimulus → M1 every time.
- Lock chain, `MAX_LOCK_TXNS`=4: M1 holds `req`/`lock` for 6 transactions while M2 requests → `m1_grant` stays high continuously across 4 `txn_done` pulses, drops after the 4th, M2 is granted next.
- Watchdog, `TIMEOUT_CYCLES`=10: M2 granted, no `txn_done` → grant drops after 10 BUSY cycles, one `timeout_abort` pulse, pending M1 granted next.
- Reset mid-LOCKED: assert `reset` low → `m1_grant`=0 immediately, `owner`=0. After release with both requesting in round-robin mode → M1 granted first.
- Withdraw: M1 drops `m1_req` in BUSY before `txn_done` → grant drops the next edge, no `timeout_abort`.
